// File: rtl/wfg_wb_master_pkg.sv
// Shared types and constants for the wfg_wb_master Wishbone command master.
package wfg_wb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RESP
    } state_e;

    localparam int unsigned WB_TIMEOUT_DEFAULT = 16;
    localparam logic [3:0]  WB_SEL_ALL         = 4'b1111;

endpackage

// File: rtl/wfg_wb_master.sv
// Single-outstanding Wishbone master: command in, one bus cycle, response out.
// Optional watchdog enabled by defining WFG_WB_MASTER_TIMEOUT_EN.
module wfg_wb_master
    import wfg_wb_master_pkg::*;
#(
    parameter int unsigned BUSW    = 32,
    parameter int unsigned TIMEOUT = WB_TIMEOUT_DEFAULT
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_we_i,
    input  logic [BUSW-1:0] cmd_adr_i,
    input  logic [BUSW-1:0] cmd_dat_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [BUSW-1:0] rsp_dat_o,
    output logic            rsp_err_o,
    output logic [BUSW-1:0] err_adr_o,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [3:0]      wbm_sel_o,
    output logic [BUSW-1:0] wbm_adr_o,
    output logic [BUSW-1:0] wbm_dat_o,
    input  logic            wbm_ack_i,
    input  logic [BUSW-1:0] wbm_dat_i
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("wfg_wb_master: TIMEOUT must be in 2..255");
    end

    state_e          r_state;
    state_e          w_state_nxt;
    logic            r_we;
    logic [BUSW-1:0] r_adr;
    logic [BUSW-1:0] r_dat;
    logic [BUSW-1:0] r_rsp_dat;
    logic            w_in_bus;
    logic            w_accept;
    logic            w_ack;
    logic            w_tmo;

    assign w_in_bus = (r_state == ST_BUS);
    // Gated with reset so the command port reads not-ready while held in reset.
    assign cmd_ready_o = (r_state == ST_IDLE) && wb_rst_ni;
    assign w_accept    = cmd_valid_i && cmd_ready_o;
    assign w_ack       = w_in_bus && wbm_ack_i;

    assign wbm_cyc_o   = w_in_bus;
    assign wbm_stb_o   = w_in_bus;
    assign wbm_we_o    = w_in_bus && r_we;
    assign wbm_sel_o   = w_in_bus ? WB_SEL_ALL : '0;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;
    assign rsp_valid_o = (r_state == ST_RESP);
    assign rsp_dat_o   = r_rsp_dat;

`ifdef WFG_WB_MASTER_TIMEOUT_EN
    logic [7:0]      r_cnt;
    logic            r_rsp_err;
    logic [BUSW-1:0] r_err_adr;

    // Terminal count loses to a coincident ack.
    assign w_tmo     = w_in_bus && !wbm_ack_i && (r_cnt == 8'(TIMEOUT - 1));
    assign rsp_err_o = r_rsp_err;
    assign err_adr_o = r_err_adr;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_cnt     <= '0;
            r_rsp_err <= 1'b0;
            r_err_adr <= '0;
        end else begin
            if (w_accept) begin
                r_cnt <= '0;
            end else if (w_in_bus && !wbm_ack_i) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_ack) begin
                r_rsp_err <= 1'b0;
            end else if (w_tmo) begin
                r_rsp_err <= 1'b1;
                r_err_adr <= r_adr;
            end
        end
    end
`else
    assign w_tmo     = 1'b0;
    assign rsp_err_o = 1'b0;
    assign err_adr_o = '0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept)           w_state_nxt = ST_BUS;
            ST_BUS:  if (w_ack || w_tmo)     w_state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready_i)        w_state_nxt = ST_IDLE;
            default:                         w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_rsp_dat <= '0;
        end else begin
            if (w_accept) begin
                r_we  <= cmd_we_i;
                r_adr <= cmd_adr_i;
                r_dat <= cmd_dat_i;
            end
            if (w_ack) begin
                r_rsp_dat <= r_we ? '0 : wbm_dat_i;
            end else if (w_tmo) begin
                r_rsp_dat <= '0;
            end
        end
    end

endmodule
